// File: rtl/core_div_unit.sv
// core_div_unit: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with tagged request/response handshakes.
module core_div_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_result,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             sa_q, sa_d, sb_q, sb_d;
  logic [XLEN:0]    rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d, div_q, div_d, res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept, is_signed, a_neg, b_neg, b_zero, ovf, take;
  logic [XLEN-1:0]  a_mag, b_mag, q_fix, r_fix, min_int, spec_res;
  logic [XLEN:0]    shl, diff;
  assign min_int   = {1'b1, {(XLEN-1){1'b0}}};
  assign accept    = req_valid && state_q == IDLE && !flush;
  assign is_signed = ~req_op[0];
  assign a_neg     = is_signed & req_a[XLEN-1];
  assign b_neg     = is_signed & req_b[XLEN-1];
  assign a_mag     = a_neg ? -req_a : req_a;
  assign b_mag     = b_neg ? -req_b : req_b;
  assign b_zero    = req_b == '0;
  assign ovf       = is_signed && req_a == min_int && req_b == '1;
  assign spec_res  = req_op[1] ? (b_zero ? req_a : '0) : (b_zero ? '1 : req_a);
  // The borrow out of the XLEN+1-bit subtract decides the quotient bit
  assign shl       = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
  assign diff      = shl - {1'b0, div_q};
  assign take      = rem_q[XLEN] | ~diff[XLEN];
  assign q_fix     = (sa_q ^ sb_q) ? -quo_q : quo_q;
  assign r_fix     = sa_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tag_d   = tag_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        op_d    = req_op;
        tag_d   = req_tag;
        sa_d    = a_neg;
        sb_d    = b_neg;
        rem_d   = '0;
        quo_d   = a_mag;
        div_d   = b_mag;
        cnt_d   = CW'(XLEN - 1);
        res_d   = spec_res;
        state_d = (b_zero || ovf) ? DONE : CALC;
      end
      CALC: begin
        rem_d   = take ? diff : shl;
        quo_d   = {quo_q[XLEN-2:0], take};
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == '0 ? FIX : CALC;
      end
      FIX: begin
        res_d   = op_q[1] ? r_fix : q_fix;
        state_d = DONE;
      end
      default: state_d = resp_ready ? IDLE : DONE;
    endcase
    if (flush) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      tag_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end
  assign req_ready   = state_q == IDLE;
  assign busy        = state_q != IDLE;
  assign resp_valid  = state_q == DONE;
  assign resp_result = res_q;
  assign resp_tag    = tag_q;
endmodule
